// File: rtl/axi_slv_mem_responder.sv
// AXI4 INCR-burst slave backed by a word-addressed memory (no ID/RESP/SIZE/BURST signals).
// Optional AXI_SLV_RAND_STALL_EN adds LFSR-driven wready/rvalid stalls for stress testing.
module axi_slv_mem_responder #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH          = 4096,
  parameter logic [15:0] STALL_SEED         = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast
);

  localparam int unsigned StrbW   = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_e                      w_state_q;
  logic                          awready_q, wready_q, bvalid_q;
  logic [IdxW-1:0]               widx_q;
  logic [7:0]                    wlen_q, wcnt_q;

  r_state_e                      r_state_q;
  logic                          arready_q, rvalid_q, rlast_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [IdxW-1:0]               ridx_q;
  logic [7:0]                    rlen_q, rcnt_q;

  logic                          stall;
  logic                          w_hs;

`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q & ~stall;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rlast   = rlast_q;

  assign w_hs = s_axi_wvalid & s_axi_wready;

  // Address bits outside the word index and wlast are intentionally ignored.
  logic unused_in;
  assign unused_in = ^{s_axi_awaddr, s_axi_araddr, s_axi_wlast};

  // Write channel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          awready_q <= 1'b1;
          if (s_axi_awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            widx_q    <= s_axi_awaddr[AddrLsb +: IdxW];
            wlen_q    <= s_axi_awlen;
            wcnt_q    <= '0;
            w_state_q <= WData;
          end
        end
        WData: begin
          if (w_hs) begin
            // Burst length comes from awlen alone; wlast is not consulted.
            if (wcnt_q == wlen_q) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              w_state_q <= WResp;
            end else begin
              wcnt_q <= wcnt_q + 8'd1;
              widx_q <= widx_q + 1'b1;
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Memory contents are never reset.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < StrbW; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read channel; fetches use non-blocking reads so a same-cycle write is seen as old data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            ridx_q    <= s_axi_araddr[AddrLsb +: IdxW];
            rlen_q    <= s_axi_arlen;
            rcnt_q    <= '0;
            r_state_q <= RFetch;
          end
        end
        RFetch: begin
          rdata_q   <= mem[ridx_q];
          rlast_q   <= (rlen_q == 8'd0);
          rvalid_q  <= ~stall;
          r_state_q <= RData;
        end
        RData: begin
          if (!rvalid_q) begin
            if (!stall) rvalid_q <= 1'b1;
          end else if (s_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= RIdle;
            end else begin
              // Fetch the next word on the handshake to sustain one beat per clock.
              rdata_q  <= mem[ridx_q + 1'b1];
              ridx_q   <= ridx_q + 1'b1;
              rcnt_q   <= rcnt_q + 8'd1;
              rlast_q  <= ((rcnt_q + 8'd1) == rlen_q);
              rvalid_q <= ~stall;
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slv_mem_responder.sv
// Directed bench for axi_slv_mem_responder with a 16-word memory so wrap-around is reachable.
module tb_axi_slv_mem_responder;

  logic        clk;
  logic        rstn;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic        rlast;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model [16];

  axi_slv_mem_responder #(
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .MEM_DEPTH(16),
    .STALL_SEED(16'hACE1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_awaddr (awaddr),
    .s_axi_awlen  (awlen),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wlast  (wlast),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_araddr (araddr),
    .s_axi_arlen  (arlen),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .s_axi_rdata  (rdata),
    .s_axi_rlast  (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_awready"}, awready, 1'b0);
    chk1({tag, "_wready"}, wready, 1'b0);
    chk1({tag, "_bvalid"}, bvalid, 1'b0);
    chk1({tag, "_arready"}, arready, 1'b0);
    chk1({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk1({tag, "_rlast"}, rlast, 1'b0);
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    awvalid = 1'b1; awaddr = a; awlen = len;
    while (!awready && n < 20) begin tick(); n++; end
    chk1("aw_ready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    arvalid = 1'b1; araddr = a; arlen = len;
    while (!arready && n < 20) begin tick(); n++; end
    chk1("ar_ready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic do_b(input int delay);
    int n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk1("b_valid", bvalid, 1'b1);
    for (int k = 0; k < delay; k++) begin
      tick();
      chk1("b_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk1("b_done", bvalid, 1'b0);
    chk1("aw_rearm", awready, 1'b1);
  endtask

  // Beat i carries base+i; the bvalid check is exactly one clock after the last beat.
  task automatic wr_burst(input logic [31:0] a, input int len, input logic [31:0] base,
                          input logic [3:0] strb);
    do_aw(a, 8'(len));
    chk1("w_ready_lat", wready, 1'b1);
    wvalid = 1'b1;
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      int w = (int'(a >> 2) + i) % 16;
      wdata = base + i; wstrb = strb; wlast = (i == len);
      while (!wready && n < 20) begin tick(); n++; end
      chk1("w_beat_ready", wready, 1'b1);
      for (int b = 0; b < 4; b++) if (strb[b]) model[w][b*8 +: 8] = wdata[b*8 +: 8];
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk1("b_lat", bvalid, 1'b1);
  endtask

  // rready held high; first rvalid exactly two clocks after the AR handshake.
  task automatic rd_burst(input logic [31:0] a, input int len);
    do_ar(a, 8'(len));
    chk1("r_fetch_idle", rvalid, 1'b0);
    tick();
    rready = 1'b1;
    for (int i = 0; i <= len; i++) begin
      int w = (int'(a >> 2) + i) % 16;
      chk1("r_valid", rvalid, 1'b1);
      chk("r_data", rdata, model[w]);
      chk1("r_last", rlast, i == len);
      tick();
    end
    rready = 1'b0;
    chk1("r_end", rvalid, 1'b0);
    chk1("ar_rearm", arready, 1'b1);
  endtask

  initial begin
    int beat;
    int cyc;
    rstn = 1'b0;
    awvalid = 0; awaddr = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    bready = 0; arvalid = 0; araddr = 0; arlen = 0; rready = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'hx;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    tick();
    chk1("post_reset_awready", awready, 1'b1);
    chk1("post_reset_arready", arready, 1'b1);

    // Single write then read
    wr_burst(32'h10, 0, 32'hDEADBEEF, 4'hF);
    do_b(0);
    rd_burst(32'h10, 0);

    // 16-beat burst at 0x100 (word 64 -> word 0 in a 16-deep memory)
    wr_burst(32'h100, 15, 32'h0, 4'hF);
    do_b(0);
    rd_burst(32'h100, 15);

    // Byte strobes: 0x11223344 then 0xAABBCCDD with strobe 0x5 -> 0x11BB33DD
    wr_burst(32'h20, 0, 32'h11223344, 4'hF);
    do_b(0);
    wr_burst(32'h20, 0, 32'hAABBCCDD, 4'h5);
    do_b(0);
    do_ar(32'h20, 8'd0);
    tick();
    chk("strobe_merge", rdata, 32'h11BB33DD);
    rready = 1'b1; tick(); rready = 1'b0;

    // Backpressure: 8-beat write, bready late by 5 clocks; read with rready 1,0,0,...
    wr_burst(32'h40, 7, 32'h100, 4'hF);
    do_b(5);
    do_ar(32'h40, 8'd7);
    tick();
    beat = 0;
    cyc = 0;
    while (beat < 8 && cyc < 100) begin
      rready = (cyc % 3 == 0);
      if (rvalid) begin
        chk("bp_data", rdata, 32'h100 + beat);
        chk1("bp_last", rlast, beat == 7);
        if (rready) beat++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    chk("bp_beats", beat, 8);
    chk1("bp_end", rvalid, 1'b0);

    // Wrap plus same-cycle read of word 0 while it is written (read-first)
    awvalid = 1'b1; awaddr = 32'h38; awlen = 8'd3;
    chk1("wrap_awready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    chk1("wrap_wready", wready, 1'b1);
    wvalid = 1'b1; wstrb = 4'hF; wlast = 1'b0; wdata = 32'hC0000000;
    tick();
    wdata = 32'hC0000001;
    arvalid = 1'b1; araddr = 32'h0; arlen = 8'd0;
    chk1("conc_arready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    wdata = 32'hC0000002;
    tick();
    wdata = 32'hC0000003; wlast = 1'b1;
    chk1("conc_rvalid", rvalid, 1'b1);
    chk("conc_old_data", rdata, 32'h00000100);
    chk1("conc_rlast", rlast, 1'b1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk1("wrap_b_lat", bvalid, 1'b1);
    chk("conc_hold", rdata, 32'h00000100);
    rready = 1'b1; tick(); rready = 1'b0;
    chk1("conc_end", rvalid, 1'b0);
    do_b(0);
    model[14] = 32'hC0000000; model[15] = 32'hC0000001;
    model[0]  = 32'hC0000002; model[1]  = 32'hC0000003;
    rd_burst(32'h38, 4);

    // Reset during beat 3 of a 10-beat read
    do_ar(32'h0, 8'd9);
    tick();
    rready = 1'b1;
    repeat (3) tick();
    chk("rst_mid_beat3", rdata, 32'h00000103);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    rready = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk1("rst_rel_arready", arready, 1'b1);
    rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk1("rst_no_stray_rvalid", rvalid, 1'b0);
      chk1("rst_no_stray_bvalid", bvalid, 1'b0);
      tick();
    end
    rready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
